// File: rtl/multibank_block_buffer_if.sv
// -----------------------------------------------------------------------------
// multibank_block_buffer_if
// Stream bundle for multibank_block_buffer: one write stream (s_*) into the
// buffer and one read stream (m_*) out of it.
//   s_data  : write data word          s_valid : write word valid
//   s_last  : early block terminator   s_ready : buffer can take a word
//   m_data  : read data (registered)   m_valid : m_data valid
//   m_last  : final word of a block    m_ready : downstream accepts m_data
// Modports:
//   master : the environment side (drives s_*, m_ready)
//   slave  : the buffer side (drives s_ready, m_data, m_valid, m_last)
// -----------------------------------------------------------------------------
interface multibank_block_buffer_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/multibank_block_buffer.sv
// -----------------------------------------------------------------------------
// multibank_block_buffer
// N-bank block buffer. The writer fills one bank with a block of BLOCK_LEN
// words, then moves to the next bank round-robin. The reader drains only
// completed banks, oldest first, over a valid/ready stream with m_last on the
// final word of each block. Consecutive full banks stream without a bubble.
//
// Ports:
//   clk        : single clock for logic and storage
//   rst_n      : asynchronous active-low reset (release synchronous to clk)
//   bus        : slave modport of multibank_block_buffer_if (s_* in, m_* out)
//   full_banks : banks completed and not yet fully drained
//   overflow   : sticky, set when s_valid is seen while s_ready = 0
//
// Optional feature macro: BLK_FLUSH_EN
//   defined   : a write with s_last = 1 closes the current bank early; a
//               per-bank last-word index is stored for the reader.
//   undefined : s_last is ignored; every block is exactly BLOCK_LEN words.
// -----------------------------------------------------------------------------
module multibank_block_buffer #(
  parameter int DATA_W    = 24,
  parameter int BLOCK_LEN = 80,
  parameter int NUM_BANKS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  multibank_block_buffer_if.slave          bus,
  output logic [$clog2(NUM_BANKS+1)-1:0]   full_banks,
  output logic                             overflow
);
  localparam int CW    = $clog2(BLOCK_LEN);
  localparam int IW    = $clog2(NUM_BANKS);
  localparam int FW    = $clog2(NUM_BANKS + 1);
  localparam int DEPTH = NUM_BANKS * BLOCK_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_LEN - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_BANKS - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IDX_MAX) ? '0 : i + 1'b1;
  endfunction

  // All banks share one RAM; bank b occupies words [b*BLOCK_LEN, (b+1)*BLOCK_LEN).
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0]        wr_cnt_q, wr_cnt_d, fetch_cnt_q, fetch_cnt_d;
  logic [IW-1:0]        wr_idx_q, wr_idx_d, fetch_idx_q, fetch_idx_d;
  logic [IW-1:0]        rd_idx_q, rd_idx_d;
  // full_q[b]: bank b is FULL or DRAINING. A bank with full_q = 0 is FREE,
  // or FILLING when it is the write bank.
  logic [NUM_BANKS-1:0] full_q, full_d;
  // vis_q[b]: full_q delayed by one cycle on the rising side only, so a bank
  // is fetched no earlier than two edges after its last write, and never
  // after it has been released.
  logic [NUM_BANKS-1:0] vis_q, vis_d;
  logic [FW-1:0]        full_banks_q, full_banks_d;
  logic                 overflow_q, overflow_d;
  logic                 m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_W-1:0]    m_data_q;

  logic                 wr_fire, wr_close, out_fire, drain_done, load, fetch_last;
  logic [CW-1:0]        fetch_end;
  logic [AW-1:0]        wr_addr, rd_addr;

  assign bus.s_ready = !full_q[wr_idx_q];
  assign wr_fire     = bus.s_valid && bus.s_ready;
  assign out_fire    = m_valid_q && bus.m_ready;
  assign drain_done  = out_fire && m_last_q;
  // The fetch pointer runs ahead of the output register: it loads the next
  // word whenever the output register is empty or being consumed, which also
  // prefetches the next bank while the previous block's last word is shown.
  assign load        = vis_q[fetch_idx_q] && (!m_valid_q || bus.m_ready);
  assign fetch_last  = (fetch_cnt_q == fetch_end);

  assign wr_addr = AW'(wr_idx_q) * AW'(BLOCK_LEN) + AW'(wr_cnt_q);
  assign rd_addr = AW'(fetch_idx_q) * AW'(BLOCK_LEN) + AW'(fetch_cnt_q);

`ifdef BLK_FLUSH_EN
  logic [CW-1:0] last_idx_q [NUM_BANKS];

  assign wr_close  = wr_fire && ((wr_cnt_q == CNT_MAX) || bus.s_last);
  assign fetch_end = last_idx_q[fetch_idx_q];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_len
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_idx_q[gi] <= CNT_MAX;
      end else if (wr_close && (wr_idx_q == IW'(gi))) begin
        last_idx_q[gi] <= wr_cnt_q;
      end
    end
  end
`else
  logic unused_s_last;

  assign unused_s_last = bus.s_last;
  assign wr_close      = wr_fire && (wr_cnt_q == CNT_MAX);
  assign fetch_end     = CNT_MAX;
`endif

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      full_d[b] = full_q[b];
      if (wr_close && (wr_idx_q == IW'(b))) full_d[b] = 1'b1;
      if (drain_done && (rd_idx_q == IW'(b))) full_d[b] = 1'b0;
      vis_d[b] = full_q[b] & full_d[b];
    end
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_idx_d    = wr_idx_q;
    fetch_cnt_d = fetch_cnt_q;
    fetch_idx_d = fetch_idx_q;
    rd_idx_d    = rd_idx_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;

    if (wr_close) begin
      wr_cnt_d = '0;
      wr_idx_d = next_idx(wr_idx_q);
    end else if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    if (load) begin
      m_valid_d = 1'b1;
      m_last_d  = fetch_last;
      if (fetch_last) begin
        fetch_cnt_d = '0;
        fetch_idx_d = next_idx(fetch_idx_q);
      end else begin
        fetch_cnt_d = fetch_cnt_q + 1'b1;
      end
    end else if (out_fire) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (drain_done) rd_idx_d = next_idx(rd_idx_q);

    unique case ({wr_close, drain_done})
      2'b10:   full_banks_d = full_banks_q + 1'b1;
      2'b01:   full_banks_d = full_banks_q - 1'b1;
      default: full_banks_d = full_banks_q;
    endcase

    overflow_d = overflow_q | (bus.s_valid & ~bus.s_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q     <= '0;
      wr_idx_q     <= '0;
      fetch_cnt_q  <= '0;
      fetch_idx_q  <= '0;
      rd_idx_q     <= '0;
      full_q       <= '0;
      vis_q        <= '0;
      full_banks_q <= '0;
      overflow_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_idx_q     <= wr_idx_d;
      fetch_cnt_q  <= fetch_cnt_d;
      fetch_idx_q  <= fetch_idx_d;
      rd_idx_q     <= rd_idx_d;
      full_q       <= full_d;
      vis_q        <= vis_d;
      full_banks_q <= full_banks_d;
      overflow_q   <= overflow_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
    end
  end

  // Storage write port; the fetched bank is never the write bank, so there is
  // no read/write collision on the same address.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= bus.s_data;
  end

  // Synchronous RAM read straight into the output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
    end else if (load) begin
      m_data_q <= mem[rd_addr];
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;
  assign full_banks  = full_banks_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_multibank_block_buffer.sv
// -----------------------------------------------------------------------------
// tb_multibank_block_buffer
// Self-checking bench: a queue-based model of the buffer (blocks become
// readable two edges after completion, banks occupied = blocks completed and
// not drained) is compared against the DUT at every falling edge, plus a few
// literal expectations. Build with +define+BLK_FLUSH_EN for the flush scenario.
// -----------------------------------------------------------------------------
module tb_multibank_block_buffer;
  localparam int DW  = 24;
  localparam int BL  = 80;
  localparam int NB  = 3;
  localparam int FW  = $clog2(NB + 1);
  localparam int LIM = 20000;
`ifdef BLK_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
    int            rdy;
  } wrd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] full_banks;
  logic          overflow;

  multibank_block_buffer_if #(.DATA_W(DW)) bif ();

  multibank_block_buffer #(
    .DATA_W(DW), .BLOCK_LEN(BL), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .full_banks(full_banks), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state
  wrd_t          out_q[$];
  logic [DW-1:0] part_q[$];
  int            occ = 0;
  bit            m_ovf = 1'b0;
  bit            e_mvalid = 1'b0;

  // output handshake log (cleared by reset)
  int hs_n = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int lastpos[$];

  bit man_ready = 1'b0;
  bit rnd_mode = 1'b0;
  int w79 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_clear();
    out_q.delete();
    part_q.delete();
    occ = 0;
    m_ovf = 1'b0;
    e_mvalid = 1'b0;
    hs_n = 0;
    first_cyc = 0;
    last_cyc = 0;
    lastpos.delete();
  endtask

  task automatic model_step();
    bit   sr;
    wrd_t w;
    int   sz;
    sr = (occ < NB);
    if (bif.s_valid && !sr) m_ovf = 1'b1;
    if (e_mvalid && bif.m_ready) begin
      w = out_q.pop_front();
      if (w.l) occ--;
    end
    if (bif.s_valid && sr) begin
      part_q.push_back(bif.s_data);
      if (part_q.size() == BL || (FLUSH && bif.s_last)) begin
        sz = part_q.size();
        for (int i = 0; i < sz; i++)
          out_q.push_back('{d: part_q[i], l: (i == sz - 1), rdy: cyc + 2});
        part_q.delete();
        occ++;
      end
    end
  endtask

  // model update on the rising edge, comparison on the falling edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_clear();
      else model_step();
      @(negedge clk);
      if (!rst_n) model_clear();
      e_mvalid = (out_q.size() != 0) && (cyc >= out_q[0].rdy);
      chk("s_ready", bif.s_ready, (occ < NB));
      chk("full_banks", full_banks, occ);
      chk("overflow", overflow, m_ovf);
      chk("m_valid", bif.m_valid, e_mvalid);
      if (e_mvalid) begin
        chk("m_data", bif.m_data, out_q[0].d);
        chk("m_last", bif.m_last, out_q[0].l);
      end
      if (rst_n && bif.m_valid && bif.m_ready) begin
        if (hs_n == 0) first_cyc = cyc;
        if (bif.m_last) lastpos.push_back(hs_n);
        last_cyc = cyc;
        hs_n++;
      end
    end
  end

  // m_ready driver: manual level or 50% random, updated each cycle
  initial begin
    bif.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      bif.m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : man_ready;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_block(input int n, input int base, input int last_at, input bit rnd);
    int gap;
    int g;
    for (int i = 0; i < n; i++) begin
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      if (gap != 0) bif.s_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      g = 0;
      while (!bif.s_ready && g < LIM) begin
        bif.s_valid = 1'b0;
        @(posedge clk);
        #1;
        g++;
      end
      if (g >= LIM) begin
        chk("write_timeout", g, 0);
        bif.s_valid = 1'b0;
        return;
      end
      bif.s_valid = 1'b1;
      bif.s_data  = rnd ? DW'($urandom) : DW'(base + i);
      bif.s_last  = (i == last_at);
      @(posedge clk);
      #1;
    end
    bif.s_valid = 1'b0;
    bif.s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (out_q.size() != 0 && g < LIM) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_words_left", out_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    bif.s_last  = 1'b0;
    do_reset();

    // reset values
    chk("rst_s_ready", bif.s_ready, 1);
    chk("rst_m_valid", bif.m_valid, 0);
    chk("rst_m_last", bif.m_last, 0);
    chk("rst_m_data", bif.m_data, 0);
    chk("rst_full_banks", full_banks, 0);
    chk("rst_overflow", overflow, 0);

    // 1: two blocks streamed continuously, m_ready = 1
    man_ready = 1'b1;
    for (int i = 0; i < 2 * BL; i++) begin
      bif.s_valid = 1'b1;
      bif.s_data  = DW'(i);
      @(posedge clk);
      #1;
      if (i == BL - 1) w79 = cyc;
    end
    bif.s_valid = 1'b0;
    wait_drain();
    chk("t1_first_valid_latency", first_cyc - w79, 2);
    chk("t1_gapless_span", last_cyc - first_cyc, 2 * BL - 1);
    chk("t1_num_last", lastpos.size(), 2);
    chk("t1_last_pos0", (lastpos.size() > 0) ? lastpos[0] : -1, 79);
    chk("t1_last_pos1", (lastpos.size() > 1) ? lastpos[1] : -1, 159);

    // 3: random valid/ready, 20 blocks
    do_reset();
    rnd_mode = 1'b1;
    for (int b = 0; b < 20; b++) write_block(BL, 0, -1, 1'b1);
    wait_drain();
    rnd_mode = 1'b0;

    // 4: bank 1 completes in the same cycle bank 0 is released
    do_reset();
    man_ready = 1'b0;
    write_block(BL, 100, -1, 1'b0);
    write_block(BL - 1, 200, -1, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("t4_m_valid_held", bif.m_valid, 1);
    man_ready = 1'b1;
    for (int i = 0; i < BL - 1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t4_full_banks_before", full_banks, 1);
    bif.s_valid = 1'b1;
    bif.s_data  = DW'(200 + BL - 1);
    @(posedge clk);
    #1;
    bif.s_valid = 1'b0;
    chk("t4_full_banks_same_cycle", full_banks, 1);
    wait_drain();

    // 2: fill every bank with m_ready = 0, overflow, then release
    do_reset();
    man_ready = 1'b0;
    write_block(NB * BL, 0, -1, 1'b0);
    chk("t2_s_ready_low", bif.s_ready, 0);
    chk("t2_full_banks", full_banks, 3);
    bif.s_valid = 1'b1;
    bif.s_data  = DW'(NB * BL);
    @(posedge clk);
    #1;
    bif.s_valid = 1'b0;
    chk("t2_overflow", overflow, 1);
    man_ready = 1'b1;
    for (int i = 0; i < BL - 1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t2_s_ready_before_release", bif.s_ready, 0);
    @(posedge clk);
    #1;
    chk("t2_s_ready_after_release", bif.s_ready, 1);
    wait_drain();

    // 5: asynchronous reset mid-block with a full bank pending
    man_ready = 1'b0;
    write_block(BL + 40, 5000, -1, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t5_m_valid_pre", bif.m_valid, 1);
    chk("t5_overflow_pre", overflow, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", bif.m_valid, 0);
    chk("t5_full_banks", full_banks, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_s_ready", bif.s_ready, 1);
    chk("t5_m_data", bif.m_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    man_ready = 1'b1;
    write_block(BL, 7000, -1, 1'b0);
    wait_drain();

`ifdef BLK_FLUSH_EN
    // 6: short block closed by s_last, then a full block
    do_reset();
    man_ready = 1'b1;
    write_block(10, 1000, 9, 1'b0);
    write_block(BL, 2000, -1, 1'b0);
    wait_drain();
    chk("t6_num_last", lastpos.size(), 2);
    chk("t6_last_pos0", (lastpos.size() > 0) ? lastpos[0] : -1, 9);
    chk("t6_last_pos1", (lastpos.size() > 1) ? lastpos[1] : -1, 89);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
